// File: rtl/clock_pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer.
//   seq_state_e : sequencer states PLL_RST, WAIT_LOCK, STABILIZE, RELEASE, RUN
//   RETRY_W     : width of the watchdog retry counter
//   cnt_width() : width of the single shared phase counter. It must hold
//                 (largest phase length - 1) and is never narrower than 1 bit.
package clock_pll_reset_sequencer_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABILIZE,
        RELEASE,
        RUN
    } seq_state_e;

    localparam int RETRY_W = 8;

    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/clock_pll_reset_sequencer_if.sv
// Control/status bundle between the PLL reset sequencer and its surroundings.
//   pll_locked   : PLL lock indicator (asynchronous to the sequencer clock)
//   sw_reset_req : level request to restart the sequence
//   clr_status   : one-cycle pulse clearing lock_lost and retry_count
//   pll_rst      : active-high PLL reset
//   domain_rstnn : active-low staged domain resets, bit 0 released first
//   seq_done     : high while the sequencer is in RUN
//   lock_lost    : sticky, lock dropped while in RUN
//   retry_count  : saturating watchdog retry count
// master = sequencer side, slave = system/PLL side.
interface clock_pll_reset_sequencer_if #(
    parameter int NUM_DOMAINS = 3
);
    import clock_pll_reset_sequencer_pkg::*;

    logic                   pll_locked;
    logic                   sw_reset_req;
    logic                   clr_status;
    logic                   pll_rst;
    logic [NUM_DOMAINS-1:0] domain_rstnn;
    logic                   seq_done;
    logic                   lock_lost;
    logic [RETRY_W-1:0]     retry_count;

    modport master (
        input  pll_locked,
        input  sw_reset_req,
        input  clr_status,
        output pll_rst,
        output domain_rstnn,
        output seq_done,
        output lock_lost,
        output retry_count
    );

    modport slave (
        output pll_locked,
        output sw_reset_req,
        output clr_status,
        input  pll_rst,
        input  domain_rstnn,
        input  seq_done,
        input  lock_lost,
        input  retry_count
    );

endinterface

// File: rtl/clock_pll_sync_bit.sv
// N-stage single-bit synchronizer; every flop resets to 0 so a reset always
// reads as "not locked" until the input has been sampled STAGES times.
//   clk   : destination clock
//   rstnn : asynchronous active-low reset
//   d_i   : asynchronous input bit
//   q_o   : synchronized output (last stage)
module clock_pll_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rstnn,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    assign sync_d = {sync_q[STAGES-2:0], d_i};

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/clock_pll_reset_sequencer.sv
// PLL reset sequencer, clocked from the free-running reference clock.
// Holds the PLL in reset, waits for a synchronized and stable lock, then
// releases the downstream domain resets one at a time. Loss of lock in
// RELEASE/RUN or a software request tears everything down and restarts.
//   clk   : free-running reference clock
//   rstnn : asynchronous active-low reset
//   bus   : control/status bundle (master modport), see the interface file
// Optional watchdog: define CLOCK_PLL_RESET_SEQUENCER_WATCHDOG_EN to retry the
// PLL after LOCK_TIMEOUT cycles without lock in WAIT_LOCK; otherwise WAIT_LOCK
// waits forever and retry_count reads 0.
module clock_pll_reset_sequencer
    import clock_pll_reset_sequencer_pkg::*;
#(
    parameter int LOCK_SYNC_STAGES = 2,
    parameter int PLL_RST_CYCLES   = 16,
    parameter int STABLE_CYCLES    = 1024,
    parameter int NUM_DOMAINS      = 3,
    parameter int STAGE_GAP        = 8,
    parameter int LOCK_TIMEOUT     = 65536
) (
    input  logic                         clk,
    input  logic                         rstnn,
    clock_pll_reset_sequencer_if.master  bus
);

    localparam int CNT_W = cnt_width(PLL_RST_CYCLES, STABLE_CYCLES, STAGE_GAP, LOCK_TIMEOUT);

    // Terminal counts: the counter starts at 0 on entry to each phase.
    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);
`ifdef CLOCK_PLL_RESET_SEQUENCER_WATCHDOG_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
`endif

    logic                   locked_s;
    seq_state_e             state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   pll_rst_q;
    logic [NUM_DOMAINS-1:0] domain_q;
    logic [NUM_DOMAINS-1:0] domain_shift_d;
    logic                   seq_done_q;
    logic                   lock_lost_q;
    logic                   restart;
`ifdef CLOCK_PLL_RESET_SEQUENCER_WATCHDOG_EN
    logic [RETRY_W-1:0]     retry_q;
`endif

    clock_pll_sync_bit #(
        .STAGES (LOCK_SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .rstnn (rstnn),
        .d_i   (bus.pll_locked),
        .q_o   (locked_s)
    );

    // Release mask grows from bit 0 upward: 001 -> 011 -> 111.
    assign domain_shift_d = (domain_q << 1) | NUM_DOMAINS'(1);

    // Teardown applies in every state; in PLL_RST it simply restarts the
    // reset-hold counter, which keeps the PLL in reset while sw_reset_req is high.
    assign restart = bus.sw_reset_req ||
                     (!locked_s && (state_q == RELEASE || state_q == RUN));

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            pll_rst_q   <= 1'b1;
            domain_q    <= '0;
            seq_done_q  <= 1'b0;
            lock_lost_q <= 1'b0;
`ifdef CLOCK_PLL_RESET_SEQUENCER_WATCHDOG_EN
            retry_q     <= '0;
`endif
        end else begin
            // Clear first; any set later in this block overrides it.
            if (bus.clr_status) begin
                lock_lost_q <= 1'b0;
`ifdef CLOCK_PLL_RESET_SEQUENCER_WATCHDOG_EN
                retry_q     <= '0;
`endif
            end

            if (restart) begin
                if (!locked_s && state_q == RUN) begin
                    lock_lost_q <= 1'b1;
                end
                state_q    <= PLL_RST;
                cnt_q      <= '0;
                pll_rst_q  <= 1'b1;
                domain_q   <= '0;
                seq_done_q <= 1'b0;
            end else begin
                case (state_q)
                    PLL_RST: begin
                        if (cnt_q == PLL_RST_LAST) begin
                            state_q   <= WAIT_LOCK;
                            cnt_q     <= '0;
                            pll_rst_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    WAIT_LOCK: begin
                        if (locked_s) begin
                            state_q <= STABILIZE;
                            cnt_q   <= '0;
                        end
`ifdef CLOCK_PLL_RESET_SEQUENCER_WATCHDOG_EN
                        else if (cnt_q == TIMEOUT_LAST) begin
                            state_q   <= PLL_RST;
                            cnt_q     <= '0;
                            pll_rst_q <= 1'b1;
                            retry_q   <= (retry_q == '1) ? retry_q : retry_q + 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
`endif
                    end
                    STABILIZE: begin
                        if (!locked_s) begin
                            state_q <= WAIT_LOCK;
                            cnt_q   <= '0;
                        end else if (cnt_q == STABLE_LAST) begin
                            cnt_q    <= '0;
                            domain_q <= NUM_DOMAINS'(1);
                            if (NUM_DOMAINS == 1) begin
                                state_q    <= RUN;
                                seq_done_q <= 1'b1;
                            end else begin
                                state_q <= RELEASE;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    RELEASE: begin
                        if (cnt_q == GAP_LAST) begin
                            cnt_q    <= '0;
                            domain_q <= domain_shift_d;
                            if (&domain_shift_d) begin
                                state_q    <= RUN;
                                seq_done_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    RUN: begin
                        cnt_q <= '0;
                    end
                    default: begin
                        state_q    <= PLL_RST;
                        cnt_q      <= '0;
                        pll_rst_q  <= 1'b1;
                        domain_q   <= '0;
                        seq_done_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.pll_rst      = pll_rst_q;
    assign bus.domain_rstnn = domain_q;
    assign bus.seq_done     = seq_done_q;
    assign bus.lock_lost    = lock_lost_q;
`ifdef CLOCK_PLL_RESET_SEQUENCER_WATCHDOG_EN
    assign bus.retry_count  = retry_q;
`else
    assign bus.retry_count  = '0;
`endif

endmodule

// File: tb/tb_clock_pll_reset_sequencer.sv
// Bench for clock_pll_reset_sequencer. Stimulus pushes the expected outputs of
// each clock edge into a queue; a monitor on the falling edge pops and compares.
// The reference model tracks event timestamps (restart, lock wait, qualify
// start, first release) and derives outputs arithmetically from elapsed time.
module tb_clock_pll_reset_sequencer;
    localparam int L = 2;   // LOCK_SYNC_STAGES
    localparam int P = 4;   // PLL_RST_CYCLES
    localparam int S = 8;   // STABLE_CYCLES
    localparam int N = 3;   // NUM_DOMAINS
    localparam int G = 2;   // STAGE_GAP
    localparam int T = 32;  // LOCK_TIMEOUT
    localparam int HIST = 16384;
`ifdef CLOCK_PLL_RESET_SEQUENCER_WATCHDOG_EN
    localparam int NOLOCK_CYCLES = 260 * (P + T);
`else
    localparam int NOLOCK_CYCLES = 300;
`endif

    typedef struct {
        int              cyc;
        logic [N+10:0]   v;    // {pll_rst, domain_rstnn, seq_done, lock_lost, retry_count}
    } sb_t;

    logic clk = 1'b0;
    logic rstnn = 1'b0;
    always #5 clk = ~clk;

    clock_pll_reset_sequencer_if #(.NUM_DOMAINS(N)) bus ();

    clock_pll_reset_sequencer #(
        .LOCK_SYNC_STAGES (L),
        .PLL_RST_CYCLES   (P),
        .STABLE_CYCLES    (S),
        .NUM_DOMAINS      (N),
        .STAGE_GAP        (G),
        .LOCK_TIMEOUT     (T)
    ) dut (
        .clk   (clk),
        .rstnn (rstnn),
        .bus   (bus)
    );

    int   checks = 0;
    int   failures = 0;
    sb_t  exp_q[$];

    // Reference model state
    int   n = 0;            // clock edge counter
    int   rel_edge;         // last edge seen with rstnn low
    int   restart_e, wait_e, qual_e, relz_e;
    logic m_lost;
    int   m_retry;
    int   m_bits;
    logic pl_at [HIST];

    function automatic int rel_bits(input int e);
        int k;
        if (relz_e < 0) return 0;
        k = (e - relz_e) / G + 1;
        return (k > N) ? N : k;
    endfunction

    task automatic restart_at(input int e);
        restart_e = e;
        wait_e    = -1;
        qual_e    = -1;
        relz_e    = -1;
    endtask

    task automatic model_reset();
        rel_edge = n;
        restart_at(n);
        m_lost   = 1'b0;
        m_retry  = 0;
        m_bits   = 0;
    endtask

    task automatic model_edge(input logic sw, input logic clr);
        logic ls;
        logic running;
        logic set_lost;
        logic inc;
        ls       = (n - L > rel_edge) ? pl_at[n-L] : 1'b0;
        running  = (relz_e >= 0) && (rel_bits(n - 1) == N);
        set_lost = 1'b0;
        inc      = 1'b0;
        if (sw || (!ls && relz_e >= 0)) begin
            set_lost = !ls && running;
            restart_at(n);
        end else if (wait_e < 0) begin
            if (n == restart_e + P) wait_e = n;
        end else if (qual_e < 0) begin
            if (ls) qual_e = n;
`ifdef CLOCK_PLL_RESET_SEQUENCER_WATCHDOG_EN
            else if (n == wait_e + T) begin
                restart_at(n);
                inc = 1'b1;
            end
`endif
        end else if (relz_e < 0) begin
            if (!ls) begin
                qual_e = -1;
                wait_e = n;
            end else if (n == qual_e + S) begin
                relz_e = n;
            end
        end
        m_lost  = set_lost ? 1'b1 : (clr ? 1'b0 : m_lost);
        m_retry = inc ? ((m_retry >= 255) ? 255 : m_retry + 1) : (clr ? 0 : m_retry);
        m_bits  = rel_bits(n);
    endtask

    function automatic logic [N+10:0] model_out();
        logic [N-1:0] dom;
        dom = N'((1 << m_bits) - 1);
        return {(wait_e < 0), dom, (m_bits == N), m_lost, 8'(m_retry)};
    endfunction

    function automatic logic [N+10:0] dut_out();
        return {bus.pll_rst, bus.domain_rstnn, bus.seq_done, bus.lock_lost, bus.retry_count};
    endfunction

    task automatic tick(input logic pl, input logic sw, input logic clr);
        sb_t s;
        bus.pll_locked   = pl;
        bus.sw_reset_req = sw;
        bus.clr_status   = clr;
        @(posedge clk);
        n++;
        if (n < HIST) pl_at[n] = pl;
        #1;
        model_edge(sw, clr);
        s.cyc = n;
        s.v   = model_out();
        exp_q.push_back(s);
    endtask

    task automatic check_direct(input string name, input logic [N+10:0] act, input logic [N+10:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%b required=%b", name, act, req);
        end else begin
            $display("ok   %s outputs=%b", name, act);
        end
    endtask

    // Advance until the model reaches the given release-bit count; bounded.
    task automatic run_until_bits(input string name, input int bits, input logic pl);
        bit found;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick(pl, 1'b0, 1'b0);
            if (m_bits == bits) found = 1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL %s timeout got_bits=%0d required_bits=%0d", name, m_bits, bits);
        end
    endtask

    // Monitor: one comparison per clock, printing a line when outputs change.
    initial begin : monitor
        sb_t           s;
        logic [N+10:0] a;
        logic [N+10:0] prev;
        prev = '1;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                s = exp_q.pop_front();
                a = dut_out();
                checks++;
                if (a !== s.v) begin
                    failures++;
                    $display("FAIL outputs cyc=%0d got pll_rst=%b dom=%b done=%b lost=%b retry=%0d required pll_rst=%b dom=%b done=%b lost=%b retry=%0d",
                             s.cyc, a[N+10], a[N+9:10], a[9], a[8], a[7:0],
                             s.v[N+10], s.v[N+9:10], s.v[9], s.v[8], s.v[7:0]);
                end else if (a !== prev) begin
                    $display("ok   cyc=%0d pll_rst=%b dom=%b done=%b lost=%b retry=%0d",
                             s.cyc, a[N+10], a[N+9:10], a[9], a[8], a[7:0]);
                end
                prev = a;
            end
        end
    end

    localparam logic [N+10:0] RESET_OUT = {1'b1, {N{1'b0}}, 1'b0, 1'b0, 8'd0};

    initial begin : stim
        int   hold;
        logic pl_r;
        bus.pll_locked   = 1'b0;
        bus.sw_reset_req = 1'b0;
        bus.clr_status   = 1'b0;
        for (int i = 0; i < HIST; i++) pl_at[i] = 1'b0;

        // Reset, then check reset values before any active edge.
        repeat (3) begin @(posedge clk); n++; end
        @(negedge clk);
        rstnn = 1'b1;
        model_reset();
        #1;
        check_direct("reset_state", dut_out(), RESET_OUT);

        // Lock appears after the 10th edge; full release and RUN.
        repeat (10) tick(1'b0, 1'b0, 1'b0);
        repeat (25) tick(1'b1, 1'b0, 1'b0);

        // Restart, then a 3-cycle lock glitch in the middle of STABILIZE.
        tick(1'b0, 1'b1, 1'b0);
        repeat (8) tick(1'b0, 1'b0, 1'b0);
        repeat (5) tick(1'b1, 1'b0, 1'b0);
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        run_until_bits("glitch_recovery_run", N, 1'b1);

        // Lock drops in RUN: lock_lost set, then cleared by clr_status.
        repeat (5) tick(1'b1, 1'b0, 1'b0);
        repeat (4) tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        repeat (3) tick(1'b0, 1'b0, 1'b0);

        // sw_reset_req pulse while domain_rstnn=011, then full resequence.
        run_until_bits("reach_release_011", 2, 1'b1);
        tick(1'b1, 1'b1, 1'b0);
        run_until_bits("resequence_after_sw", N, 1'b1);
        repeat (3) tick(1'b1, 1'b0, 1'b0);

        // Randomized lock behaviour, software requests and status clears.
        for (int i = 0; i < 1500; ) begin
            hold = $urandom_range(1, 40);
            pl_r = ($urandom_range(0, 3) != 0);
            for (int j = 0; j < hold; j++) begin
                tick(pl_r, ($urandom_range(0, 79) == 0), ($urandom_range(0, 29) == 0));
                i++;
            end
        end

        // No lock at all: watchdog retries (or indefinite wait).
        tick(1'b0, 1'b1, 1'b1);
        repeat (NOLOCK_CYCLES) tick(1'b0, 1'b0, 1'b0);

        // Reach RUN, then assert rstnn between edges.
        run_until_bits("run_before_async_reset", N, 1'b1);
        repeat (2) tick(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        rstnn = 1'b0;
        #1;
        check_direct("async_reset_in_run", dut_out(), RESET_OUT);
        repeat (3) begin
            @(posedge clk);
            n++;
            if (n < HIST) pl_at[n] = bus.pll_locked;
        end
        @(negedge clk);
        rstnn = 1'b1;
        model_reset();
        run_until_bits("run_after_reset", N, 1'b1);
        repeat (3) tick(1'b1, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clock_pll_reset_sequencer.md
Name: clock_pll_reset_sequencer

Overview:
- Controls the board clock PLL that generates clk_system from the differential external clock.
- Holds the PLL in reset for a fixed time, waits for a synchronized and stable lock, then releases up to NUM_DOMAINS downstream reset domains one at a time.
- Watches lock continuously. On loss of lock or a software request, it re-asserts all domain resets and restarts the sequence.
- Clocked from the free-running external reference clock, not from the PLL output.

Parameters:
- LOCK_SYNC_STAGES, 2: synchronizer depth on pll_locked (minimum 2).
- PLL_RST_CYCLES, 16: number of cycles pll_rst is held high per attempt (minimum 1).
- STABLE_CYCLES, 1024: number of consecutive synchronized-lock cycles required before release (minimum 1).
- NUM_DOMAINS, 3: number of staged reset outputs (minimum 1).
- STAGE_GAP, 8: cycles between successive domain releases (minimum 1).
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK before a retry (used only with the watchdog feature).

Ports:
- clk  in  1  free-running reference clock.
- rstnn  in  1  asynchronous active-low reset.
- pll_locked  in  1  PLL lock indicator, asynchronous to clk.
- sw_reset_req  in  1  level request to restart the sequence, synchronous to clk.
- clr_status  in  1  one-cycle pulse that clears lock_lost and retry_count.
- pll_rst  out  1  active-high PLL reset.
- domain_rstnn  out  NUM_DOMAINS  active-low resets to downstream domains; bit 0 is released first.
- seq_done  out  1  high while in RUN.
- lock_lost  out  1  sticky flag: lock dropped while in RUN.
- retry_count  out  8  saturating count of watchdog retries.

Behaviour:
- Reset and clocking: one clock, clk. rstnn is asynchronous and active-low. All outputs are registered.
- Values while rstnn=0 and after reset: pll_rst=1, domain_rstnn=all 0, seq_done=0, lock_lost=0, retry_count=0, state=PLL_RST with its counter at 0.
- locked_s is pll_locked passed through a LOCK_SYNC_STAGES-flop synchronizer whose flops reset to 0. All decisions below use locked_s.
- PLL_RST state:
  - pll_rst=1 and all domains held in reset.
  - After PLL_RST_CYCLES cycles in this state, go to WAIT_LOCK; pll_rst goes low on entry to WAIT_LOCK.
- WAIT_LOCK state: when locked_s=1, go to STABILIZE with the stability counter cleared.
- STABILIZE state:
  - Increment the counter on each cycle with locked_s=1.
  - If locked_s=0, return to WAIT_LOCK and clear the counter.
  - On the STABLE_CYCLES-th consecutive count, go to RELEASE. domain_rstnn[0]=1 on the entry cycle.
  - Timing: if locked_s rises at cycle t, domain_rstnn[0] rises at t+1+STABLE_CYCLES.
- RELEASE state:
  - domain_rstnn[i] rises STAGE_GAP cycles after domain_rstnn[i-1].
  - Once released, bits stay released.
  - After bit NUM_DOMAINS-1 is released, go to RUN. seq_done rises in the same cycle as the last bit.
  - If NUM_DOMAINS=1, go directly to RUN.
- Loss of lock or software request (any state except PLL_RST):
  - If locked_s=0 in RELEASE or RUN, or sw_reset_req=1, the next cycle has domain_rstnn=all 0, seq_done=0, pll_rst=1, state=PLL_RST.
  - lock_lost is set only when lock drops while in RUN.
  - Lock drop and sw_reset_req in the same cycle: same transition, and lock_lost is set if in RUN.
  - sw_reset_req held high keeps the block in PLL_RST; the PLL_RST counter restarts while the request is high.
- Status flags:
  - A clr_status pulse clears lock_lost and retry_count.
  - If a set and a clear occur in the same cycle, the set wins.
- Reset mid-sequence: asserting rstnn returns to the reset values immediately, with no ordered teardown.
- Domain resets are asserted asynchronously with respect to downstream clocks. Each consuming domain synchronizes deassertion itself.

Optional Feature:
- Macro: CLOCK_PLL_RESET_SEQUENCER_WATCHDOG_EN.
- When defined:
  - A counter runs in WAIT_LOCK.
  - After LOCK_TIMEOUT cycles without locked_s, retry_count increments (saturating at 255) and the state returns to PLL_RST.
  - Time spent in STABILIZE does not advance the timeout.
- When undefined: WAIT_LOCK waits indefinitely, retry_count is tied to 0, and LOCK_TIMEOUT is unused.

Decomposition:
- Shared package clock_pll_reset_sequencer_pkg:
  - State enum with values PLL_RST, WAIT_LOCK, STABILIZE, RELEASE, RUN.
  - Counter-width helper (clog2 of the largest of PLL_RST_CYCLES, STABLE_CYCLES, STAGE_GAP, LOCK_TIMEOUT).
  - RETRY_W=8.
- One sub-module, clock_pll_sync_bit: an N-stage reset-to-0 synchronizer with parameter STAGES, reused for pll_locked.

Test Plan (bench parameters: LOCK_SYNC_STAGES=2, PLL_RST_CYCLES=4, STABLE_CYCLES=8, NUM_DOMAINS=3, STAGE_GAP=2, LOCK_TIMEOUT=32):
- Reset then pll_locked=1 at cycle 10 -> pll_rst=1 for 4 cycles. locked_s rises at 12, so domain_rstnn=001 at 21, 011 at 23, 111 at 25, and seq_done=1 at 25.
- Lock glitch low for 3 cycles mid-STABILIZE -> return to WAIT_LOCK, counter restarts. Release starts 9 cycles after locked_s returns high. domain_rstnn stays 000 throughout.
- pll_locked drops in RUN -> 2 cycles later locked_s=0. Next cycle: domain_rstnn=000, seq_done=0, pll_rst=1, lock_lost=1. A clr_status pulse then gives lock_lost=0.
- sw_reset_req pulse during RELEASE (domain_rstnn=011) -> next cycle 000 and pll_rst=1. Full resequence completes without lock_lost being set.
- Watchdog defined, pll_locked held 0 -> retry_count increments every 4+32 cycles and saturates at 255. With the macro undefined, pll_rst stays 0 indefinitely and retry_count=0.
- rstnn asserted while in RUN -> all outputs return to reset values asynchronously, before the next clk edge.
